// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared state encoding and default sizes for boot_loader
//
// Contents:
//   state_t          - loader FSM states IDLE, LOAD, DRAIN, DONE (2 bits)
//   DEF_ADDR_WIDTH   - default ROM/memory word address width
//   DEF_DATA_WIDTH   - default word width
//   DEF_WORDS        - default image length in words
package boot_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_WORDS      = 256;

endpackage

// File: rtl/boot_checksum.sv
// rtl/boot_checksum.sv - running modular sum of loaded words with zero flag
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset, clears the sum
//   clr   in   clear the sum (start of a new image)
//   add   in   accumulate data this cycle
//   data  in   DATA_WIDTH word to accumulate
//   zero  out  sum is currently zero
module boot_checksum #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  add,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  zero
);

   logic [DATA_WIDTH-1:0] sum;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sum <= '0;
      end else if (add) begin
         sum <= sum + data;
      end
   end

   assign zero = (sum == '0);

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - copies a fixed-size boot ROM image into memory, then releases the CPU
//
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN (image checksum check, drives err)
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   rdy        in   one-cycle start pulse from the bootstrap pulse generator
//   rom_addr   out  boot ROM read address
//   rom_data   in   boot ROM data, valid one cycle after rom_addr
//   mem_we     out  memory write enable
//   mem_addr   out  memory write address
//   mem_wdata  out  memory write data
//   busy       out  copy in progress (LOAD or DRAIN)
//   done       out  image loaded
//   cpu_rst    out  CPU reset, high until a successful load completes
//   err        out  checksum failure (0 when the checksum is compiled out)
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int WORDS      = DEF_WORDS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  cpu_rst,
   output logic                  err
);

   // One extra bit so WORDS == 2**ADDR_WIDTH reaches its last index without wrapping.
   localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(WORDS - 1);
   localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH+1)'(1);

   state_t                state, state_next;
   logic [ADDR_WIDTH:0]   cnt, cnt_next;
   logic                  start_q;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;

   // A start request is registered first; rdy only counts when the loader
   // is not already copying, so a pulse in LOAD/DRAIN is dropped here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         start_q <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         start_q <= rdy && ((state == IDLE) || (state == DONE));
         wr_en   <= (state == LOAD);
         if (state == LOAD) begin
            wr_addr <= cnt[ADDR_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE, DONE: begin
            if (start_q) begin
               state_next = LOAD;
               cnt_next   = '0;
            end
         end
         LOAD: begin
            if (cnt == LAST) begin
               state_next = DRAIN;
            end else begin
               cnt_next = cnt + ONE;
            end
         end
         DRAIN: begin
            state_next = DONE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign rom_addr  = cnt[ADDR_WIDTH-1:0];
   assign mem_we    = wr_en;
   assign mem_addr  = wr_addr;
   // ROM output is already registered; pass it straight through on the write cycle.
   assign mem_wdata = wr_en ? rom_data : '0;
   assign busy      = (state == LOAD) || (state == DRAIN);
   assign done      = (state == DONE);

`ifdef BOOT_LOADER_CHECKSUM_EN
   logic sum_zero;

   // The sum is cleared on the start edge and picks up the final word on
   // the same edge that enters DONE, so err is valid for the whole DONE state.
   boot_checksum #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_checksum (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_q),
      .add  (wr_en),
      .data (rom_data),
      .zero (sum_zero)
   );

   assign err = (state == DONE) && !sum_zero;
`else
   assign err = 1'b0;
`endif

   assign cpu_rst = !((state == DONE) && !err);

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader (WORDS=4 and WORDS=256 instances)
module tb_boot_loader;

`ifdef BOOT_LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance a: WORDS=4, instance b: WORDS=256
   logic       rst_a, rdy_a, we_a, busy_a, done_a, cpu_a, err_a;
   logic [7:0] ra_a, rd_a, ma_a, wd_a;
   logic       rst_b, rdy_b, we_b, busy_b, done_b, cpu_b, err_b;
   logic [7:0] ra_b, rd_b, ma_b, wd_b;

   boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WORDS(4)) u_dut_a (
      .clk(clk), .rst(rst_a), .rdy(rdy_a), .rom_addr(ra_a), .rom_data(rd_a),
      .mem_we(we_a), .mem_addr(ma_a), .mem_wdata(wd_a), .busy(busy_a),
      .done(done_a), .cpu_rst(cpu_a), .err(err_a)
   );

   boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WORDS(256)) u_dut_b (
      .clk(clk), .rst(rst_b), .rdy(rdy_b), .rom_addr(ra_b), .rom_data(rd_b),
      .mem_we(we_b), .mem_addr(ma_b), .mem_wdata(wd_b), .busy(busy_b),
      .done(done_b), .cpu_rst(cpu_b), .err(err_b)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] img  [2][256];
   logic [7:0] wmem [2][256];
   int         wr_cnt [2];
   int         w_of [2] = '{4, 256};
   bit         run_cmp = 1'b0;

   // Model: p = edges since the start request was acted on (0 = not copying)
   int         p    [2] = '{0, 0};
   bit         pend [2] = '{1'b0, 1'b0};
   bit         loaded [2] = '{1'b0, 1'b0};
   bit         eerr [2] = '{1'b0, 1'b0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] image_sum(input int id);
      logic [7:0] s = '0;
      for (int i = 0; i < w_of[id]; i++) s += img[id][i];
      return s;
   endfunction

   task automatic model_step(input int id, input logic r, input logic y);
      bit was_idle = (p[id] == 0);
      if (r) begin
         p[id] = 0; pend[id] = 1'b0; loaded[id] = 1'b0; eerr[id] = 1'b0;
      end else begin
         if (p[id] > 0) begin
            p[id]++;
            if (p[id] == w_of[id] + 2) begin
               p[id] = 0;
               loaded[id] = 1'b1;
               eerr[id] = CK && (image_sum(id) != 8'h00);
            end
         end else if (pend[id]) begin
            p[id] = 1;
            loaded[id] = 1'b0;
            eerr[id] = 1'b0;
         end
         pend[id] = y && was_idle;
      end
   endtask

   task automatic cmp(input int id, input logic busy, input logic dn, input logic cr,
                      input logic er, input logic we, input logic [7:0] ra,
                      input logic [7:0] ma, input logic [7:0] wd);
      int    pp = p[id];
      string t  = (id == 0) ? "a" : "b";
      check({t, "_busy"}, busy, pp >= 1);
      check({t, "_done"}, dn, loaded[id]);
      check({t, "_err"}, er, loaded[id] && eerr[id]);
      check({t, "_cpu_rst"}, cr, !(loaded[id] && !eerr[id]));
      check({t, "_mem_we"}, we, pp >= 2);
      if (pp >= 1 && pp <= w_of[id]) check({t, "_rom_addr"}, ra, pp - 1);
      if (pp >= 2) begin
         check({t, "_mem_addr"}, ma, pp - 2);
         check({t, "_mem_wdata"}, wd, img[id][pp-2]);
      end
   endtask

   always @(posedge clk) begin
      model_step(0, rst_a, rdy_a);
      model_step(1, rst_b, rdy_b);
   end

   // Synchronous boot ROMs
   always @(posedge clk) begin
      rd_a <= img[0][ra_a];
      rd_b <= img[1][ra_b];
   end

   always @(negedge clk) begin
      if (we_a) begin wr_cnt[0]++; wmem[0][ma_a] = wd_a; end
      if (we_b) begin wr_cnt[1]++; wmem[1][ma_b] = wd_b; end
      if (run_cmp) begin
         cmp(0, busy_a, done_a, cpu_a, err_a, we_a, ra_a, ma_a, wd_a);
         cmp(1, busy_b, done_b, cpu_b, err_b, we_b, ra_b, ma_b, wd_b);
      end
   end

   // Start pulse sampled at edge 0, then edges 1..6 with literal checks.
   // rdy_edge >= 1 pulses rdy again at that edge during the copy.
   task automatic load_a(input string tag, input bit bad, input int rdy_edge);
      logic [7:0] exp_w [4];
      exp_w = '{8'h11, 8'h22, 8'h33, 8'h9A};
      if (bad) exp_w[3] = 8'h00;
      rdy_a = 1'b1;
      @(negedge clk);
      for (int e = 1; e <= 6; e++) begin
         rdy_a = (e == rdy_edge);
         @(negedge clk);
         if (e == 1) begin
            check({tag, "_e1_busy"}, busy_a, 1);
            check({tag, "_e1_rom_addr"}, ra_a, 0);
            check({tag, "_e1_cpu_rst"}, cpu_a, 1);
            check({tag, "_e1_done"}, done_a, 0);
         end
         if (e >= 2 && e <= 5) begin
            check({tag, "_wr_we"}, we_a, 1);
            check({tag, "_wr_addr"}, ma_a, e - 2);
            check({tag, "_wr_data"}, wd_a, exp_w[e-2]);
         end
         if (e == 6) begin
            check({tag, "_e6_done"}, done_a, 1);
            check({tag, "_e6_busy"}, busy_a, 0);
            check({tag, "_e6_we"}, we_a, 0);
            check({tag, "_e6_err"}, err_a, bad && CK);
            check({tag, "_e6_cpu_rst"}, cpu_a, bad && CK);
         end
      end
      rdy_a = 1'b0;
   endtask

   initial begin
      logic [7:0] s;
      int         e;
      int         miss;
      rst_a = 1'b1; rst_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
      wr_cnt = '{0, 0};
      img[0][0] = 8'h11; img[0][1] = 8'h22; img[0][2] = 8'h33; img[0][3] = 8'h9A;
      for (int i = 4; i < 256; i++) img[0][i] = 8'hEE;
      s = '0;
      for (int i = 0; i < 255; i++) begin
         img[1][i] = 8'(i * 37 + 5);
         s += img[1][i];
      end
      img[1][255] = -s;

      @(negedge clk);
      @(negedge clk);
      run_cmp = 1'b1;
      check("rst_rom_addr", ra_a, 0);
      check("rst_mem_we", we_a, 0);
      check("rst_mem_addr", ma_a, 0);
      check("rst_mem_wdata", wd_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_cpu_rst", cpu_a, 1);
      check("rst_err", err_a, 0);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);

      load_a("normal", 1'b0, 0);
      @(negedge clk);
      img[0][3] = 8'h00;
      load_a("badsum", 1'b1, 0);
      img[0][3] = 8'h9A;
      @(negedge clk);
      load_a("rdy_in_load", 1'b0, 3);
      @(negedge clk);

      // Abort mid-load, then restart from address 0
      rdy_a = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 4; k++) begin
         rdy_a = 1'b0;
         rst_a = (k == 4);
         @(negedge clk);
         if (k == 3) check("abort_e3_we", we_a, 1);
      end
      check("abort_we", we_a, 0);
      check("abort_busy", busy_a, 0);
      check("abort_cpu_rst", cpu_a, 1);
      check("abort_done", done_a, 0);
      rst_a = 1'b0;
      @(negedge clk);
      load_a("after_abort", 1'b0, 0);
      @(negedge clk);
      load_a("warm_reload", 1'b0, 0);

      // Full address space on instance b
      wr_cnt[1] = 0;
      rdy_b = 1'b1;
      @(negedge clk);
      rdy_b = 1'b0;
      e = 0;
      while (e <= 300 && !done_b) begin
         @(negedge clk);
         e++;
      end
      check("b_done_edge", e, 258);
      check("b_write_count", wr_cnt[1], 256);
      check("b_cpu_rst", cpu_b, 0);
      miss = 0;
      for (int i = 0; i < 256; i++) if (wmem[1][i] !== img[1][i]) miss++;
      check("b_image_words_wrong", miss, 0);
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/boot_loader.md
# boot_loader

Post-reset program loader for the Riscade core. It waits for the one-cycle ready pulse that the bootstrap pulse generator emits after reset, then streams a fixed-size image from the synchronous boot ROM into main memory at one word per cycle. When the copy completes, it releases the CPU from reset. The block sits between the bootstrap pulse generator, the boot ROM and the memory write port, and owns the CPU reset line.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of ROM and memory word addresses.
- DATA_WIDTH, 8, word width.
- WORDS, 256, image length in words; legal range 2..2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- rdy  in  1  one-cycle start pulse from the bootstrap pulse generator.
- rom_addr  out  ADDR_WIDTH  boot ROM read address.
- rom_data  in  DATA_WIDTH  boot ROM data, valid one cycle after rom_addr.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory write address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- busy  out  1  copy in progress.
- done  out  1  image loaded.
- cpu_rst  out  1  CPU reset; high until a successful load completes.
- err  out  1  checksum failure; constant 0 when checksum is compiled out.

## Operation
- Reset values: state IDLE, rom_addr=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, cpu_rst=1, err=0.
- States:
  - IDLE: waits for rdy=1, then goes to LOAD with counter cnt=0.
  - LOAD: drives rom_addr=cnt and increments cnt each cycle. When cnt=WORDS-1 is issued, goes to DRAIN.
  - DRAIN: performs the final write with no new ROM address, then goes to DONE.
  - DONE: done=1. cpu_rst=0 unless err=1.
- Write pipeline:
  - A one-stage register captures the issued address.
  - In the cycle after address k is issued: mem_we=1, mem_addr=k, mem_wdata=rom_data.
- busy=1 in LOAD and DRAIN only.
- rdy in DONE starts a warm reload:
  - cpu_rst is reasserted in the same cycle the state returns to LOAD.
  - done and err are cleared.
- rdy in LOAD or DRAIN is ignored; the copy is not restarted.
- rst at any time aborts immediately:
  - all outputs return to reset values on the next edge;
  - a partial image is left in memory and is not cleaned up.
- cnt is ADDR_WIDTH+1 bits wide, so WORDS=2^ADDR_WIDTH does not wrap before the termination compare.
- mem_we never asserts outside the LOAD/DRAIN window.

## Timing
- Reference point: rdy is sampled high at edge 0.
- Edge 1: LOAD, busy=1, rom_addr=0.
- Edge k+1: rom_addr=k.
- Edge k+2: mem_we=1, mem_addr=k, mem_wdata=ROM[k].
- Edge WORDS+1: last write (address WORDS-1), state DRAIN.
- Edge WORDS+2: DONE, busy=0, mem_we=0, done=1, cpu_rst=0.
- Total latency is WORDS+2 cycles. Throughput is one word per cycle, with no stalls.

## Configuration
- Macro: BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - A DATA_WIDTH-bit running sum accumulates every written word, including the last one.
  - Entering DONE with a nonzero sum sets err=1, and cpu_rst stays 1.
  - A zero sum gives err=0 and releases cpu_rst.
  - The image's final word is the two's-complement checksum of the preceding words.
- Undefined:
  - No accumulator is built.
  - err is tied to 0, and cpu_rst always releases in DONE.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE, LOAD, DRAIN, DONE, 2 bits);
  - default ADDR_WIDTH, DATA_WIDTH and WORDS values.
- One natural sub-module, boot_checksum: a synchronous accumulator with clear, add-enable and a zero-flag output. It is instantiated only under BOOT_LOADER_CHECKSUM_EN.
- Everything else stays flat.

## Test plan
- Normal load, WORDS=4, ROM={0x11,0x22,0x33,0x9A}, checksum on:
  - rdy at edge 0 produces writes (0,0x11),(1,0x22),(2,0x33),(3,0x9A) at edges 2..5;
  - done=1, cpu_rst=0, err=0 at edge 6.
- Bad checksum: same stimulus with ROM[3]=0x00 gives err=1, done=1, cpu_rst=1 at edge 6.
- rdy pulsed again at edge 3 during LOAD is ignored: identical write sequence and completion at edge 6.
- rst asserted at edge 3 mid-load:
  - edge 4 shows IDLE, mem_we=0, busy=0, cpu_rst=1;
  - a later rdy restarts from address 0.
- Warm reload: rdy in DONE reasserts cpu_rst and clears done on the next edge, and the full write sequence repeats.
- WORDS=2^ADDR_WIDTH (256): exactly 256 writes, addresses 0..255 with no wrap, and done at edge 258.
